// File: rtl/video_timing_meter.sv
// video_timing_meter: measures line/frame geometry, sync widths and an
// active-pixel checksum of a ce_pix-qualified video stream; reports lock.
module video_timing_meter #(
    parameter int HCNT_W        = 12,
    parameter int VCNT_W        = 10,
    parameter int STABLE_FRAMES = 4,
    parameter int PAL_LINES     = 288
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce_pix,
    input  logic              HSync,
    input  logic              VSync,
    input  logic              HBlank,
    input  logic              VBlank,
    input  logic [7:0]        video_r,
    input  logic [7:0]        video_g,
    input  logic [7:0]        video_b,
    output logic [HCNT_W-1:0] h_total,
    output logic [HCNT_W-1:0] h_active,
    output logic [HCNT_W-1:0] hs_width,
    output logic [VCNT_W-1:0] v_total,
    output logic [VCNT_W-1:0] v_active,
    output logic [VCNT_W-1:0] vs_width,
    output logic [15:0]       frame_sum,
    output logic              is_pal,
    output logic              frame_done,
    output logic              locked,
    output logic              overflow
);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    localparam logic [HCNT_W-1:0] H_MAX = '1;
    localparam logic [HCNT_W-1:0] H_ONE = {{(HCNT_W-1){1'b0}}, 1'b1};
    localparam logic [VCNT_W-1:0] V_MAX = '1;
    localparam logic [VCNT_W-1:0] V_ONE = {{(VCNT_W-1){1'b0}}, 1'b1};
    localparam logic [VCNT_W-1:0] PAL_V = VCNT_W'(PAL_LINES);
    localparam logic [4:0] STAB_TGT = 5'(STABLE_FRAMES - 1);

    // {reached_max, saturating increment}
    function automatic logic [HCNT_W:0] inc_h(input logic [HCNT_W-1:0] c);
        logic sat;
        sat = (c >= H_MAX - H_ONE);
        inc_h = {sat, sat ? H_MAX : c + H_ONE};
    endfunction

    function automatic logic [VCNT_W:0] inc_v(input logic [VCNT_W-1:0] c);
        logic sat;
        sat = (c >= V_MAX - V_ONE);
        inc_v = {sat, sat ? V_MAX : c + V_ONE};
    endfunction

    state_t              state;
    logic                hs_prev, vs_prev;
    logic [HCNT_W-1:0]   h_cnt, hs_cnt, ha_cnt;
    logic [HCNT_W-1:0]   line_total, line_hs, last_active;
    logic [VCNT_W-1:0]   v_cnt, v_act_cnt, vs_cnt;
    logic [15:0]         sum_cnt;
    logic                ovf_frame;
    logic [3:0]          stab_cnt;

    logic                qs, hs_rise, vs_rise, act, timeout, same, ovf_now, ovf_c;
    logic [9:0]          pix_sum;
    logic [4:0]          stab_nxt;
    logic [HCNT_W:0]     h_i, hs_i, ha_i;
    logic [VCNT_W:0]     v_i, va_i, vs_i;
    logic [HCNT_W-1:0]   h_n, hs_n, ha_n, lt_n, lh_n, la_n;
    logic [VCNT_W-1:0]   v_n, va_n, vs_n;
    logic [15:0]         sum_n;

    assign qs       = ce_pix;
    assign hs_rise  = HSync & ~hs_prev;
    assign vs_rise  = VSync & ~vs_prev;
    assign act      = ~HBlank & ~VBlank;
    assign pix_sum  = {2'b0, video_r} + {2'b0, video_g} + {2'b0, video_b};
    assign h_i      = inc_h(h_cnt);
    assign hs_i     = inc_h(hs_cnt);
    assign ha_i     = inc_h(ha_cnt);
    assign v_i      = inc_v(v_cnt);
    assign va_i     = inc_v(v_act_cnt);
    assign vs_i     = inc_v(vs_cnt);
    assign timeout  = h_i[HCNT_W] & ~hs_rise & (state != SEARCH);
    assign stab_nxt = {1'b0, stab_cnt} + 5'd1;
    assign ovf_c    = ovf_frame | ovf_now;

    always_comb begin
        h_n     = h_i[HCNT_W-1:0];
        hs_n    = HSync ? hs_i[HCNT_W-1:0] : hs_cnt;
        ha_n    = act ? ha_i[HCNT_W-1:0] : ha_cnt;
        lt_n    = line_total;
        lh_n    = line_hs;
        la_n    = last_active;
        v_n     = v_cnt;
        va_n    = v_act_cnt;
        vs_n    = vs_cnt;
        sum_n   = act ? sum_cnt + {6'b0, pix_sum} : sum_cnt;
        ovf_now = h_i[HCNT_W] | (HSync & hs_i[HCNT_W]) | (act & ha_i[HCNT_W]);
        if (hs_rise) begin
            lt_n    = h_cnt;
            lh_n    = hs_cnt;
            h_n     = H_ONE;
            hs_n    = H_ONE;
            ha_n    = act ? H_ONE : '0;
            v_n     = v_i[VCNT_W-1:0];
            ovf_now = v_i[VCNT_W];
            if (VSync) begin
                vs_n    = vs_i[VCNT_W-1:0];
                ovf_now = ovf_now | vs_i[VCNT_W];
            end
            if (ha_cnt != '0) begin
                la_n    = ha_cnt;
                va_n    = va_i[VCNT_W-1:0];
                ovf_now = ovf_now | va_i[VCNT_W];
            end
        end
    end

    // v_total/vs_width count line starts, so the closing rise belongs to the new frame
    assign same = ({lt_n, la_n, lh_n} == {h_total, h_active, hs_width})
               && ({v_cnt, va_n, vs_cnt} == {v_total, v_active, vs_width});

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SEARCH;
            hs_prev     <= 1'b0;
            vs_prev     <= 1'b0;
            h_cnt       <= '0;
            hs_cnt      <= '0;
            ha_cnt      <= '0;
            line_total  <= '0;
            line_hs     <= '0;
            last_active <= '0;
            v_cnt       <= '0;
            v_act_cnt   <= '0;
            vs_cnt      <= '0;
            sum_cnt     <= '0;
            ovf_frame   <= 1'b0;
            stab_cnt    <= '0;
            h_total     <= '0;
            h_active    <= '0;
            hs_width    <= '0;
            v_total     <= '0;
            v_active    <= '0;
            vs_width    <= '0;
            frame_sum   <= '0;
            is_pal      <= 1'b0;
            frame_done  <= 1'b0;
            locked      <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (qs) begin
                hs_prev <= HSync;
                vs_prev <= VSync;
                if (timeout || (state == SEARCH && !vs_rise)) begin
                    h_cnt       <= '0;
                    hs_cnt      <= '0;
                    ha_cnt      <= '0;
                    line_total  <= '0;
                    line_hs     <= '0;
                    last_active <= '0;
                    v_cnt       <= '0;
                    v_act_cnt   <= '0;
                    vs_cnt      <= '0;
                    sum_cnt     <= '0;
                    ovf_frame   <= 1'b0;
                    if (timeout) begin
                        state    <= SEARCH;
                        locked   <= 1'b0;
                        stab_cnt <= '0;
                    end
                end else begin
                    h_cnt       <= h_n;
                    hs_cnt      <= hs_n;
                    ha_cnt      <= ha_n;
                    line_total  <= lt_n;
                    line_hs     <= lh_n;
                    last_active <= la_n;
                    v_cnt       <= v_n;
                    v_act_cnt   <= va_n;
                    vs_cnt      <= vs_n;
                    sum_cnt     <= sum_n;
                    ovf_frame   <= ovf_c;
                    if (vs_rise) begin
                        v_act_cnt <= '0;
                        v_cnt     <= hs_rise ? V_ONE : '0;
                        vs_cnt    <= hs_rise ? V_ONE : '0;
                        sum_cnt   <= act ? {6'b0, pix_sum} : '0;
                        ovf_frame <= 1'b0;
                        if (state == SEARCH) begin
                            state    <= MEASURE;
                            stab_cnt <= '0;
                        end else begin
                            h_total    <= lt_n;
                            h_active   <= la_n;
                            hs_width   <= lh_n;
                            v_total    <= v_cnt;
                            v_active   <= va_n;
                            vs_width   <= vs_cnt;
                            frame_sum  <= sum_cnt;
                            is_pal     <= (v_cnt >= PAL_V);
                            overflow   <= ovf_c;
                            frame_done <= 1'b1;
                            if (same && !ovf_c) begin
                                if (state == MEASURE) begin
                                    stab_cnt <= stab_nxt[3:0];
                                    if (stab_nxt >= STAB_TGT) begin
                                        state  <= LOCKED;
                                        locked <= 1'b1;
                                    end
                                end
                            end else begin
                                state    <= MEASURE;
                                locked   <= 1'b0;
                                stab_cnt <= '0;
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_video_timing_meter.sv
// tb_video_timing_meter: directed frames with hand-computed geometry,
// lock sequencing, PAL classification, timeout and mid-frame reset.
module tb_video_timing_meter;

    logic        clk = 1'b0;
    logic        reset, ce_pix, HSync, VSync, HBlank, VBlank;
    logic [7:0]  video_r, video_g, video_b;
    logic [11:0] h_total, h_active, hs_width;
    logic [9:0]  v_total, v_active, vs_width;
    logic [15:0] frame_sum;
    logic        is_pal, frame_done, locked, overflow;

    int n_chk = 0;
    int n_err = 0;
    int fd_cnt = 0;
    int fd_lk[$];
    int fd_ht[$];
    int fd_vt[$];
    int fd_pal[$];
    int base;

    video_timing_meter dut (
        .clk(clk), .reset(reset), .ce_pix(ce_pix),
        .HSync(HSync), .VSync(VSync), .HBlank(HBlank), .VBlank(VBlank),
        .video_r(video_r), .video_g(video_g), .video_b(video_b),
        .h_total(h_total), .h_active(h_active), .hs_width(hs_width),
        .v_total(v_total), .v_active(v_active), .vs_width(vs_width),
        .frame_sum(frame_sum), .is_pal(is_pal), .frame_done(frame_done),
        .locked(locked), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) begin
            fd_cnt++;
            fd_lk.push_back(int'(locked));
            fd_ht.push_back(int'(h_total));
            fd_vt.push_back(int'(v_total));
            fd_pal.push_back(int'(is_pal));
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // one qualified sample: ce_pix high for one clk out of four
    task automatic pix(input logic hs, input logic vs, input logic hb,
                       input logic vb, input logic [7:0] c);
        @(negedge clk);
        HSync = hs; VSync = vs; HBlank = hb; VBlank = vb;
        video_r = c; video_g = c; video_b = c;
        ce_pix = 1'b1;
        @(negedge clk);
        ce_pix = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic frame(input int lines, input int len, input int last_len,
                         input int rst_line);
        for (int l = 0; l < lines; l++) begin
            int n;
            n = (l == lines - 1) ? last_len : len;
            for (int p = 0; p < n; p++) begin
                if (l == rst_line && p == 10) begin
                    @(negedge clk); reset = 1'b1;
                    @(negedge clk); reset = 1'b0;
                    chk("rst_mid_h_total", h_total, 0);
                    chk("rst_mid_v_total", v_total, 0);
                    chk("rst_mid_locked", locked, 0);
                end
                pix(p < 2, l < 3, p < 4, l < 2, 8'd1);
            end
        end
    endtask

    initial begin
        reset = 1'b1; ce_pix = 1'b0;
        HSync = 1'b0; VSync = 1'b0; HBlank = 1'b0; VBlank = 1'b0;
        video_r = '0; video_g = '0; video_b = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_h_total", h_total, 0);
        chk("rst_v_total", v_total, 0);
        chk("rst_frame_sum", frame_sum, 0);
        chk("rst_locked", locked, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_is_pal", is_pal, 0);

        // six identical frames: results for frames 1..5, lock on the 4th
        repeat (6) frame(10, 20, 20, -1);
        chk("lock_fd_cnt", fd_cnt, 5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("lock_seq%0d", i), fd_lk[i], (i >= 3) ? 1 : 0);
        chk("nom_h_total", h_total, 20);
        chk("nom_h_active", h_active, 16);
        chk("nom_hs_width", hs_width, 2);
        chk("nom_v_total", v_total, 10);
        chk("nom_v_active", v_active, 8);
        chk("nom_vs_width", vs_width, 3);
        chk("nom_frame_sum", frame_sum, 384);
        chk("nom_is_pal", is_pal, 0);
        chk("nom_overflow", overflow, 0);

        // last line of frame 7 is 21 pixels, then clean frames 8..12
        frame(10, 20, 21, -1);
        repeat (5) frame(10, 20, 20, -1);
        chk("pert_fd_cnt", fd_cnt, 11);
        chk("pert_h_total", fd_ht[6], 21);
        for (int i = 5; i < 11; i++)
            chk($sformatf("relock_seq%0d", i), fd_lk[i],
                (i == 5 || i == 10) ? 1 : 0);
        chk("relock_now", locked, 1);

        // HSync stops: h_cnt saturates, back to SEARCH
        base = fd_cnt;
        repeat (4096) pix(1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
        chk("to_locked", locked, 0);
        chk("to_h_total_held", h_total, 20);
        chk("to_v_total_held", v_total, 10);
        chk("to_sum_held", frame_sum, 384);
        chk("to_fd_cnt", fd_cnt, base);

        frame(312, 8, 8, -1);
        chk("to_no_done", fd_cnt, base);
        frame(287, 8, 8, -1);
        chk("pal_fd_cnt", fd_cnt, base + 1);
        chk("pal_v_total", v_total, 312);
        chk("pal_is_pal", is_pal, 1);
        chk("pal_h_total", h_total, 8);
        chk("pal_h_active", h_active, 4);
        chk("pal_v_active", v_active, 310);
        chk("pal_overflow", overflow, 0);

        // closes the 287-line frame, then reset during line 5
        frame(10, 20, 20, 5);
        chk("ntsc_fd_cnt", fd_cnt, base + 2);
        chk("ntsc_v_total", fd_vt[base + 1], 287);
        chk("ntsc_is_pal", fd_pal[base + 1], 0);
        chk("rst_after_h_total", h_total, 0);
        chk("rst_after_sum", frame_sum, 0);
        chk("rst_after_is_pal", is_pal, 0);

        base = fd_cnt;
        frame(10, 20, 20, -1);
        chk("rst_first_rise", fd_cnt, base);
        frame(10, 20, 20, -1);
        chk("rst_second_rise", fd_cnt, base + 1);
        chk("rst_res_h_total", h_total, 20);
        chk("rst_res_v_total", v_total, 10);
        chk("rst_res_v_active", v_active, 8);
        chk("rst_res_sum", frame_sum, 384);
        chk("rst_res_locked", locked, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/video_timing_meter.md
# video_timing_meter

Receive-side companion to the test-pattern video path. Consumes the same pixel stream the pattern generator drives toward the video output (ce_pix, HSync, VSync, HBlank, VBlank, 8-bit R/G/B) and measures it. It reports line and frame geometry, sync widths, a per-frame active-pixel checksum, PAL/NTSC classification and a lock indication. It sits in parallel with the VGA_* outputs, in the video clock domain, so the bench and on-target debug can confirm that what is emitted matches the selected mode.

## Interface
- HCNT_W, 12: width of horizontal counters (ce_pix units).
- VCNT_W, 10: width of vertical counters (lines).
- STABLE_FRAMES, 4: consecutive identical frames required to assert locked; range 1..15.
- PAL_LINES, 288: v_total at or above this sets is_pal.
- clk  in  1  video clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- ce_pix  in  1  pixel enable; all inputs are sampled only when high.
- HSync, VSync  in  1  active-high syncs.
- HBlank, VBlank  in  1  active-high blanking.
- video_r, video_g, video_b  in  8  pixel colour.
- h_total  out  HCNT_W  ce_pix count from one HSync rise to the next.
- h_active  out  HCNT_W  active pixels in the last line of the frame that had any.
- hs_width  out  HCNT_W  HSync-high ce_pix count in the last completed line.
- v_total  out  VCNT_W  lines per frame.
- v_active  out  VCNT_W  lines with at least one active pixel.
- vs_width  out  VCNT_W  lines started while VSync is high.
- frame_sum  out  16  sum mod 2^16 of (r+g+b) over active pixels.
- is_pal  out  1  v_total >= PAL_LINES.
- frame_done  out  1  one-clk pulse when the result registers update.
- locked  out  1  geometry is stable.
- overflow  out  1  some counter saturated in the last frame.

## Operation
- Qualified sample (QS): a clk cycle with ce_pix=1. Edge detectors hold the previous HSync and VSync values, updated only on QS. A rise is prev=0 and current=1.
- Active pixel: QS with HBlank=0 and VBlank=0.
- Line counters: h_cnt increments every QS. hs_cnt increments on QS with HSync=1. ha_cnt increments on active pixels. On an HSync rise:
  - h_cnt → line_total, then h_cnt=1 (the rising sample counts as pixel 0 of the new line).
  - hs_cnt → line_hs, then hs_cnt reloads with 1.
  - If ha_cnt≠0, it is stored as last_active and v_act_cnt increments. ha_cnt then clears.
  - v_cnt increments. If VSync=1, vs_cnt increments.
- Frame close happens on a VSync rise. Result registers load from line_total, last_active, line_hs, v_cnt, v_act_cnt, vs_cnt and sum_cnt. The frame counters then clear.
- If HSync and VSync rise on the same QS, the line close is applied first and the frame close sees the updated counts. The new frame therefore starts with v_cnt=1 and vs_cnt=1.
- Checksum: sum_cnt += {2'b0,r}+{2'b0,g}+{2'b0,b} on each active pixel, wrapping at 16 bits.
- Saturation: counters stop at all-ones and never wrap. Any saturation sets a sticky ovf_frame flag, which is copied to overflow at frame close and then cleared.
- FSM states:
  - SEARCH: reset state. Counters are held clear. On the first VSync rise → MEASURE with no result update.
  - MEASURE: at each frame close, load the results and pulse frame_done. Compare {h_total,h_active,hs_width,v_total,v_active,vs_width} with the previous frame.
    - Equal and no overflow: stab_cnt++. When stab_cnt reaches STABLE_FRAMES-1 → LOCKED.
    - Otherwise stab_cnt=0.
  - LOCKED: loads and pulses exactly as in MEASURE. Any mismatch or overflow → MEASURE with stab_cnt=0 and locked deasserted.
  - Timeout: h_cnt saturating in any state → SEARCH. Outputs keep their last values, and locked is cleared.
- The checksum does not take part in the lock comparison.

## Timing
- Reset: all outputs are 0, FSM is SEARCH, edge-detector history is 0.
- frame_done asserts in the clk cycle after the QS that carries the VSync rise, for exactly one clk, together with the new result values. Latency is 1 clk.
- locked changes in the same cycle as frame_done.
- Cycles with ce_pix=0 change no state, except that reset still applies.
- Reset asserted mid-frame discards the partial frame. Outputs are zero in the following cycle.

## Test plan
- Nominal stream, ce_pix every 4th clk:
  - Stimulus: line of 20 pixels (HSync high for pixels 0–1, HBlank for pixels 0–3, 16 active); frame of 10 lines (VSync high on lines 0–2, VBlank on lines 0–1, 8 active lines); all pixels r=g=b=1.
  - Required response: h_total=20, h_active=16, hs_width=2, v_total=10, v_active=8, vs_width=3, frame_sum=384, is_pal=0.
- Lock: six identical frames with STABLE_FRAMES=4 → frame_done on frames 1–5; locked asserts with the 4th result; is_pal=0.
- Perturbation: after lock, one line lengthened to 21 pixels → locked drops at that frame close and re-asserts after 4 further clean frames.
- PAL classification: v_total=312 → is_pal=1. v_total=287 → is_pal=0.
- Timeout: stop HSync for 4096 QS → state SEARCH, locked=0, prior values held. The next VSync rise produces no frame_done.
- Reset mid-frame: reset high for one clk during line 5 → all outputs 0. The first frame_done occurs after the second subsequent VSync rise.
